pwm_duty_sequencer: RTL and testbench
=====================================

Name: pwm_duty_sequencer

Overview:
- Upstream feeder for the basic PWM generator. Replaces its hard-coded duty list with a writable table of up to DEPTH duty values.
- Steps through the table, holding each value for a programmable number of PWM periods, with optional looping.
- Updates the duty output only on PWM period boundaries, so the PWM comparator never sees a mid-period change.

Parameters:
- R, 5, duty/counter width; must match the PWM stage R.
- DEPTH, 8, table entries; power of two.
- AW, 3, address width; equals log2(DEPTH).
- HW, 8, hold-counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_data  in  R  duty value to write.
- seq_last  in  AW  index of the last active entry; latched at start.
- hold  in  HW  each step lasts hold+1 PWM periods; latched at start.
- loop  in  1  1 = wrap to entry 0 after seq_last, 0 = stop; latched at start.
- start  in  1  one-cycle pulse that begins a sequence.
- stop  in  1  one-cycle pulse that aborts the sequence.
- period_end  in  1  one-cycle clk-domain strobe from the PWM stage, asserted when its counter equals 2**R-1.
- duty  out  R  duty value to the PWM comparator.
- idx  out  AW  index of the entry currently driven.
- busy  out  1  high in ARM or RUN.
- step_pulse  out  1  one-cycle strobe when duty is reloaded.
- seq_done  out  1  one-cycle strobe when a non-looping sequence ends.

Behaviour:
- Reset (async, reset=0):
  - State = IDLE.
  - duty=0, idx=0, busy=0, step_pulse=0, seq_done=0.
  - Hold counter = 0; latched config = 0; all table entries = 0.
- Table write:
  - On a clk edge with wr_en=1, table[wr_addr] <= wr_data.
  - Writes are accepted in every state.
  - An entry is read only at the moment it is loaded into duty; rewriting the live entry has no effect until its next load.
  - Write and load of the same address in the same cycle: the load takes the old value.
- State IDLE:
  - duty held at 0, busy=0.
  - start=1 -> latch seq_last, hold, loop; go to ARM.
- State ARM (busy=1):
  - Waits for period_end.
  - On period_end: duty<=table[0], idx<=0, hold counter<=0, step_pulse=1; go to RUN.
- State RUN (busy=1), on each period_end:
  - If hold counter < latched hold: increment the hold counter; duty unchanged.
  - Else clear the hold counter, then:
    - if idx < latched seq_last: idx<=idx+1, duty<=table[idx+1], step_pulse=1;
    - else if loop=1: idx<=0, duty<=table[0], step_pulse=1;
    - else: duty<=0, idx<=0, seq_done=1; go to IDLE.
- Latency:
  - duty, idx, step_pulse and seq_done are registered and change on the clk edge that samples period_end=1.
  - Without period_end, outputs never change (except on stop or reset).
- stop:
  - From any state, the next edge forces IDLE with duty=0, idx=0, hold counter=0.
  - No seq_done and no step_pulse on stop.
- Priority and edge cases:
  - stop beats start and period_end in the same cycle.
  - start while busy is ignored; latched config is unchanged.
  - start and period_end in the same cycle in IDLE: go to ARM only. The first load waits for the next period_end, so a full period always precedes the first new value.
  - hold=0: step on every period_end.
  - seq_last=0: a single entry is repeated (loop=1) or played once (loop=0).
  - seq_last, hold and loop input changes during RUN are ignored.
  - Counters wrap only through the explicit compare logic; no arithmetic overflow is reachable.
- Reset asserted mid-sequence: immediate return to reset values, including clearing the table.

Test Plan:
- Reset, write table {24,31,19,17,12,6,0,19}, seq_last=7, hold=0, loop=0, start, then 9 period_end pulses -> duty sequence 24,31,19,17,12,6,0,19, then 0; seq_done exactly once on the 9th period_end; busy low afterwards.
- hold=2, seq_last=1, loop=1, table {8,16} -> duty 8 for 3 periods, 16 for 3, 8 again; step_pulse on the 1st, 4th and 7th period_end; no seq_done.
- Pulse stop two cycles after a step while running -> next edge duty=0, idx=0, busy=0; no seq_done or step_pulse; a later start re-arms correctly.
- Rewrite table[1]=5 while idx=0 is live -> duty for step 1 is 5; rewriting table[0] while it is live leaves duty unchanged until reload.
- start with period_end in the same cycle -> state ARM and duty still 0; first load occurs on the next period_end. start and stop together -> remains IDLE.
- Assert reset while in RUN with duty=31 -> duty=0, busy=0 immediately (asynchronously); after release and a fresh start, all entries read 0.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_duty_sequencer
//
// Feeds the PWM comparator with duty values taken from a small writable table.
// The table is stepped through one entry at a time. Each entry is held for
// (hold+1) PWM periods. After the last active entry the sequence either wraps
// to entry 0 or stops. duty only changes on the clk edge that samples
// period_end, so the comparator never sees a change in the middle of a period.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset (also clears the table)
//   wr_en       table write strobe; accepted in every state
//   wr_addr     table write address
//   wr_data     duty value to write
//   seq_last    index of the last active entry (latched on start)
//   hold        extra periods per step, step = hold+1 periods (latched on start)
//   loop        1 = wrap to entry 0 after seq_last, 0 = stop (latched on start)
//   start       one-cycle pulse, begins a sequence when idle
//   stop        one-cycle pulse, aborts the sequence from any state
//   period_end  one-cycle strobe from the PWM stage at its last count
//   duty        duty value to the PWM comparator
//   idx         index of the entry currently driven
//   busy        high while armed or running
//   step_pulse  one-cycle strobe when duty is reloaded from the table
//   seq_done    one-cycle strobe when a non-looping sequence finishes
// -----------------------------------------------------------------------------
module pwm_duty_sequencer #(
    parameter int R     = 5,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int HW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [R-1:0]  wr_data,
    input  logic [AW-1:0] seq_last,
    input  logic [HW-1:0] hold,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    input  logic          period_end,
    output logic [R-1:0]  duty,
    output logic [AW-1:0] idx,
    output logic          busy,
    output logic          step_pulse,
    output logic          seq_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [R-1:0]  tbl [DEPTH];

    logic [HW-1:0] hold_cnt;
    logic [AW-1:0] cfg_last;
    logic [HW-1:0] cfg_hold;
    logic          cfg_loop;

    logic [R-1:0]  duty_nxt;
    logic [AW-1:0] idx_nxt;
    logic [HW-1:0] hold_cnt_nxt;
    logic          step_nxt;
    logic          done_nxt;
    logic          cfg_ld;

    logic [AW-1:0] idx_inc;
    logic          hold_over;
    logic          at_last;

    // idx_inc is only used when idx < cfg_last, so it never wraps.
    assign idx_inc   = idx + AW'(1);
    assign hold_over = (hold_cnt >= cfg_hold);
    assign at_last   = (idx >= cfg_last);
    assign busy      = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop overrides everything else
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start)      state_nxt = S_ARM;
                S_ARM:  if (period_end) state_nxt = S_RUN;
                S_RUN: begin
                    if (period_end && hold_over && at_last && !cfg_loop) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values. Table reads here see the pre-edge
    // contents, so a same-cycle write to the loaded address yields old data.
    always_comb begin
        duty_nxt     = duty;
        idx_nxt      = idx;
        hold_cnt_nxt = hold_cnt;
        step_nxt     = 1'b0;
        done_nxt     = 1'b0;
        cfg_ld       = 1'b0;
        if (stop) begin
            duty_nxt     = '0;
            idx_nxt      = '0;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    duty_nxt = '0;
                    cfg_ld   = start;
                end
                S_ARM: begin
                    if (period_end) begin
                        duty_nxt     = tbl[0];
                        idx_nxt      = '0;
                        hold_cnt_nxt = '0;
                        step_nxt     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (period_end) begin
                        if (!hold_over) begin
                            hold_cnt_nxt = hold_cnt + HW'(1);
                        end else begin
                            hold_cnt_nxt = '0;
                            if (!at_last) begin
                                idx_nxt  = idx_inc;
                                duty_nxt = tbl[idx_inc];
                                step_nxt = 1'b1;
                            end else if (cfg_loop) begin
                                idx_nxt  = '0;
                                duty_nxt = tbl[0];
                                step_nxt = 1'b1;
                            end else begin
                                idx_nxt  = '0;
                                duty_nxt = '0;
                                done_nxt = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    duty_nxt     = '0;
                    idx_nxt      = '0;
                    hold_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Registered outputs, hold counter and latched configuration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty       <= '0;
            idx        <= '0;
            hold_cnt   <= '0;
            step_pulse <= 1'b0;
            seq_done   <= 1'b0;
            cfg_last   <= '0;
            cfg_hold   <= '0;
            cfg_loop   <= 1'b0;
        end else begin
            duty       <= duty_nxt;
            idx        <= idx_nxt;
            hold_cnt   <= hold_cnt_nxt;
            step_pulse <= step_nxt;
            seq_done   <= done_nxt;
            if (cfg_ld) begin
                cfg_last <= seq_last;
                cfg_hold <= hold;
                cfg_loop <= loop;
            end
        end
    end

    // Duty table; cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_en) begin
            tbl[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_sequencer
//
// Stimulus drives one clock at a time and, right after each edge, advances a
// behavioural model of the sequencer (play position + periods remaining).
// Every reload or end-of-sequence the model predicts is pushed into a queue;
// a monitor on the falling edge pops and compares whenever the DUT raises
// step_pulse or seq_done, and also checks duty/idx/busy against the model.
// -----------------------------------------------------------------------------
module tb_pwm_duty_sequencer;

    localparam int R = 5, DEPTH = 8, AW = 3, HW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [R-1:0]  wr_data = '0;
    logic [AW-1:0] seq_last = '0;
    logic [HW-1:0] hold = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          period_end = 1'b0;
    logic [R-1:0]  duty;
    logic [AW-1:0] idx;
    logic          busy;
    logic          step_pulse;
    logic          seq_done;

    pwm_duty_sequencer #(.R(R), .DEPTH(DEPTH), .AW(AW), .HW(HW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .seq_last(seq_last), .hold(hold), .loop(loop),
        .start(start), .stop(stop), .period_end(period_end), .duty(duty),
        .idx(idx), .busy(busy), .step_pulse(step_pulse), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int duty;
        int idx;
        int step;
        int done;
    } ev_t;

    ev_t exp_q[$];

    // Behavioural model: mode 0 idle, 1 waiting for first period, 2 playing
    int m_mode = 0;
    int m_pos = 0;
    int m_left = 0;
    int m_last = 0;
    int m_hold = 0;
    int m_loop = 0;
    int m_duty = 0;
    int m_idx = 0;
    int m_tab[DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_ev(input int d, input int i, input int s, input int dn);
        ev_t e;
        e.duty = d; e.idx = i; e.step = s; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic model_load(input int p);
        m_pos  = p;
        m_duty = m_tab[p];
        m_idx  = p;
        m_left = m_hold + 1;
        push_ev(m_duty, m_idx, 1, 0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_left = 0;
        m_last = 0; m_hold = 0; m_loop = 0;
        m_duty = 0; m_idx = 0;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge with the inputs that edge sampled.
    task automatic model_step(input bit we, input int wa, input int wd,
                              input bit st, input bit sp, input bit pe);
        if (sp) begin
            m_mode = 0; m_duty = 0; m_idx = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                m_last = int'(seq_last);
                m_hold = int'(hold);
                m_loop = int'(loop);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (pe) begin
                model_load(0);
                m_mode = 2;
            end
        end else if (pe) begin
            m_left--;
            if (m_left == 0) begin
                if (m_pos < m_last) model_load(m_pos + 1);
                else if (m_loop != 0) model_load(0);
                else begin
                    m_duty = 0; m_idx = 0; m_mode = 0;
                    push_ev(0, 0, 0, 1);
                end
            end
        end
        if (we) m_tab[wa] = wd;
    endtask

    // One clock of stimulus.
    task automatic cyc(input bit we, input int wa, input int wd,
                       input bit st, input bit sp, input bit pe);
        wr_en = we; wr_addr = AW'(wa); wr_data = R'(wd);
        start = st; stop = sp; period_end = pe;
        @(posedge clk);
        model_step(we, wa, wd, st, sp, pe);
        #1;
        wr_en = 1'b0; start = 1'b0; stop = 1'b0; period_end = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        cyc(1'b1, a, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pe_n(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (step_pulse || seq_done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: got step=%0b done=%0b, expected none (t=%0t)",
                             step_pulse, seq_done, $time);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("ev_step", 32'(step_pulse), 32'(e.step));
                    chk("ev_done", 32'(seq_done), 32'(e.done));
                    chk("ev_duty", 32'(duty), 32'(e.duty));
                    chk("ev_idx", 32'(idx), 32'(e.idx));
                end
            end else if (exp_q.size() != 0) begin
                checks++; errors++;
                $display("FAIL missed_event: got no strobe, expected duty=%0d step=%0d done=%0d (t=%0t)",
                         exp_q[0].duty, exp_q[0].step, exp_q[0].done, $time);
                exp_q.delete();
            end
            chk("duty", 32'(duty), 32'(m_duty));
            chk("idx", 32'(idx), 32'(m_idx));
            chk("busy", 32'(busy), 32'(m_mode != 0));
        end
    end

    initial begin
        int tab1[8] = '{24, 31, 19, 17, 12, 6, 0, 19};
        model_reset();

        // Reset state
        #12;
        chk("rst_duty", 32'(duty), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step_pulse), 32'd0);
        chk("rst_done", 32'(seq_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Full 8-entry non-looping sequence, hold=0
        for (int i = 0; i < 8; i++) wr(i, tab1[i]);
        seq_last = 3'd7; hold = 8'd0; loop = 1'b0;
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        pe_n(9);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_duty_after", 32'(duty), 32'd0);

        // Looping two-entry sequence with hold=2
        wr(0, 8); wr(1, 16);
        seq_last = 3'd1; hold = 8'd2; loop = 1'b1;
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        pe_n(7);
        chk("t2_duty_p7", 32'(duty), 32'd8);
        // config changes while running are ignored
        seq_last = 3'd5; hold = 8'd0; loop = 1'b0;
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        pe_n(5);
        // stop two cycles after a step
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("t3_stop_busy", 32'(busy), 32'd0);
        chk("t3_stop_duty", 32'(duty), 32'd0);
        seq_last = 3'd1; hold = 8'd0; loop = 1'b1;
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        pe_n(3);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

        // Live-entry rewrites and same-cycle write/load
        wr(0, 10); wr(1, 20);
        seq_last = 3'd1; hold = 8'd1; loop = 1'b1;
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        pe_n(1);
        wr(1, 5); wr(0, 3);
        chk("t4_live_duty", 32'(duty), 32'd10);
        pe_n(2);
        chk("t4_step1_duty", 32'(duty), 32'd5);
        pe_n(1);
        cyc(1'b1, 0, 7, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

        // start together with period_end, then start together with stop
        seq_last = 3'd0; hold = 8'd0; loop = 1'b0;
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("t5_arm_busy", 32'(busy), 32'd1);
        chk("t5_arm_duty", 32'(duty), 32'd0);
        pe_n(2);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("t5_startstop_busy", 32'(busy), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit we, st, sp, pe;
            if ($urandom_range(0, 19) == 0) begin
                seq_last = AW'($urandom_range(0, 7));
                hold     = HW'($urandom_range(0, 3));
                loop     = 1'($urandom_range(0, 1));
            end
            we = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 99) == 0);
            pe = ($urandom_range(0, 2) == 0);
            cyc(we, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), st, sp, pe);
        end
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-run with duty=31
        wr(0, 31);
        seq_last = 3'd0; hold = 8'd3; loop = 1'b1;
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        pe_n(1);
        chk("t6_pre_duty", 32'(duty), 32'd31);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_async_duty", 32'(duty), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        seq_last = 3'd7; hold = 8'd0; loop = 1'b0;
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        pe_n(9);

        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
